// File: rtl/gpio_in.sv
// gpio_in: memory-mapped general-purpose input port.
//
// External pins go through a two-flop synchroniser and are then sampled on
// a slow prescaler tick. A pin level is accepted (debounced) once it is the
// same at two consecutive ticks. A debounced 0->1 transition sets a sticky
// event flag. The processor reads either the debounced levels or the event
// flags, and reading the event flags clears them. irq is high while any
// event flag is set.
//
// Ports:
//   CLK    in   1      system clock, rising edge
//   RST_N  in   1      asynchronous active-low reset
//   a      in   32     processor address
//   re     in   1      read strobe
//   pins   in   WIDTH  external asynchronous inputs
//   q      out  32     registered read data
//   irq    out  1      event pending
//
// Read strobe semantics: there is no handshake back-pressure. Every rising
// edge that samples re=1 is exactly one read of address a; q carries the
// result from that edge on and holds it until the next read. With re=0, q
// holds and the event flags are untouched.
module gpio_in #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] DATA_ADDR = 32'h0000abce,
    parameter logic [31:0] EVT_ADDR  = 32'h0000abcf,
    parameter int          TICK_DIV  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      a,
    input  logic             re,
    input  logic [WIDTH-1:0] pins,
    output logic [31:0]      q,
    output logic             irq
);

    localparam int CW = $clog2(TICK_DIV);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] smp_q, smp_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] evt_q, evt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             tick;
    logic [WIDTH-1:0] agree;
    logic [WIDTH-1:0] rise;
    logic [31:0]      deb_ext;
    logic [31:0]      evt_ext;
    logic             rd_data;
    logic             rd_evt;

    assign tick    = (cnt_q == CW'(TICK_DIV - 1));
    // Bits whose synchronised level matches the previous tick's sample.
    assign agree   = ~(s2_q ^ smp_q);
    // Debounced bit about to go 0->1 on this edge.
    assign rise    = {WIDTH{tick}} & ~deb_q & agree & s2_q;
    assign rd_data = re && (a == DATA_ADDR);
    assign rd_evt  = re && (a == EVT_ADDR);

    always_comb begin
        deb_ext = '0;
        evt_ext = '0;
        deb_ext[WIDTH-1:0] = deb_q;
        evt_ext[WIDTH-1:0] = evt_q;
    end

    always_comb begin
        s1_d  = pins;
        s2_d  = s1_q;
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        smp_d = smp_q;
        deb_d = deb_q;
        if (tick) begin
            smp_d = s2_q;
            deb_d = (deb_q & ~agree) | (s2_q & agree);
        end
        // A rise on the same edge as the clearing read survives the clear.
        if (rd_evt) begin
            evt_d = rise;
        end else begin
            evt_d = evt_q | rise;
        end
        rdata_d = rdata_q;
        if (re) begin
            if (rd_data) begin
                rdata_d = deb_ext;
            end else if (rd_evt) begin
                rdata_d = evt_ext;
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q    <= '0;
            s2_q    <= '0;
            smp_q   <= '0;
            deb_q   <= '0;
            evt_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            smp_q   <= smp_d;
            deb_q   <= deb_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign q   = rdata_q;
    assign irq = |evt_q;

endmodule

// File: tb/tb_gpio_in.sv
module tb_gpio_in;

  localparam int          TD        = 4;
  localparam logic [31:0] DATA_ADDR = 32'h0000abce;
  localparam logic [31:0] EVT_ADDR  = 32'h0000abcf;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] a;
  logic        re;
  logic [31:0] pins;
  logic [31:0] q;
  logic        irq;

  always #5 CLK = ~CLK;

  gpio_in #(
    .WIDTH    (32),
    .DATA_ADDR(DATA_ADDR),
    .EVT_ADDR (EVT_ADDR),
    .TICK_DIV (TD)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .a    (a),
    .re   (re),
    .pins (pins),
    .q    (q),
    .irq  (irq)
  );

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // ---------------- reference model ----------------
  // Edges since reset release; pins seen one and two edges ago (the level
  // visible to the debouncer); last tick sample; accepted levels; events.
  int          k;
  logic [31:0] p1, p2, m_last, m_deb, m_evt, m_q;

  task automatic model_reset();
    k = 0; p1 = '0; p2 = '0; m_last = '0; m_deb = '0; m_evt = '0; m_q = '0;
  endtask

  function automatic logic is_tick();
    return (k % TD) == TD - 1;
  endfunction

  // Bits that become newly accepted as high at the coming edge.
  function automatic logic [31:0] m_rise();
    logic [31:0] same;
    same = ~(p2 ^ m_last);
    if (!is_tick()) return '0;
    return ~m_deb & same & p2;
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    logic [31:0] same;
    r = m_rise();
    if (re) begin
      if (a == DATA_ADDR)     m_q = m_deb;
      else if (a == EVT_ADDR) m_q = m_evt;
      else                    m_q = '0;
    end
    if (re && a == EVT_ADDR) m_evt = r;
    else                     m_evt = m_evt | r;
    if (is_tick()) begin
      same   = ~(p2 ^ m_last);
      m_deb  = (m_deb & ~same) | (p2 & same);
      m_last = p2;
    end
    p2 = p1;
    p1 = pins;
    k++;
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else        model_edge();
    @(negedge CLK);
    check("q", q, m_q);
    check("irq", {31'b0, irq}, {31'b0, |m_evt});
  endtask

  task automatic idle(input int n);
    re = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [31:0] addr);
    re = 1'b1; a = addr;
    step();
    re = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] pv);
    RST_N = 1'b0; pins = pv; re = 1'b0; a = '0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    RST_N = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic        found;
    int          hold;
    RST_N = 1'b0; re = 1'b0; a = '0; pins = '1;
    model_reset();

    phase = "reset";
    do_reset('1);
    check("q_in_reset", q, 32'h0);
    check("irq_in_reset", {31'b0, irq}, 32'h0);
    rd(DATA_ADDR);
    check("data_after_release", q, 32'h0);
    idle(12);
    rd(EVT_ADDR);

    phase = "level_event";
    do_reset('0);
    pins = 32'h5;
    idle(12);
    rd(DATA_ADDR);
    check("data", q, 32'h5);
    check("irq_set", {31'b0, irq}, 32'h1);
    rd(EVT_ADDR);
    check("evt", q, 32'h5);
    idle(1);
    check("irq_clear", {31'b0, irq}, 32'h0);
    rd(EVT_ADDR);
    check("evt_again", q, 32'h0);

    phase = "glitch";
    pins = 32'hd;
    idle(2);
    pins = 32'h5;
    idle(12);
    check("irq", {31'b0, irq}, 32'h0);
    rd(DATA_ADDR);
    check("data", q, 32'h5);
    rd(EVT_ADDR);
    check("evt", q, 32'h0);

    phase = "simul";
    pins = 32'h7;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      r = m_rise();
      if (r[1]) found = 1'b1;
      else      idle(1);
    end
    check("rise_found", {31'b0, found}, 32'h1);
    rd(EVT_ADDR);
    check("q_excl_bit1", q, 32'h0);
    check("irq_held", {31'b0, irq}, 32'h1);
    rd(EVT_ADDR);
    check("evt_next", q, 32'h2);
    rd(DATA_ADDR);
    check("data7", q, 32'h7);
    rd(32'h1234);
    check("unmapped", q, 32'h0);

    phase = "falling";
    pins = 32'h0;
    idle(12);
    check("irq", {31'b0, irq}, 32'h0);
    rd(DATA_ADDR);
    check("data", q, 32'h0);

    phase = "random";
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        pins = ($urandom_range(0, 1) == 1) ? $urandom : (pins ^ (32'h1 << $urandom_range(0, 31)));
        hold = $urandom_range(1, 12);
      end
      hold--;
      re = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0, 1:    a = DATA_ADDR;
        2:       a = EVT_ADDR;
        default: a = $urandom;
      endcase
      step();
    end
    re = 1'b0;

    phase = "reset_mid";
    do_reset('0);
    pins = 32'h5;
    idle(12);
    rd(DATA_ADDR);
    check("pre_q", q, 32'h5);
    check("pre_irq", {31'b0, irq}, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check("q_async", q, 32'h0);
    check("irq_async", {31'b0, irq}, 32'h0);
    model_reset();
    idle(2);
    @(negedge CLK);
    RST_N = 1'b1;
    re = 1'b1; a = DATA_ADDR;
    for (int i = 0; i < TD + 2; i++) begin
      step();
      check("early", q, 32'h0);
    end
    for (int i = 0; i < 8; i++) step();
    check("late", q, 32'h5);
    re = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
